// File: rtl/dram_lsu.sv
// ---------------------------------------------------------------------------
// dram_lsu
//
// Load/store sequencer and bus master for the processor's single-port data
// RAM. It takes one read or write request at a time from the datapath over
// a valid/ready handshake and drives the RAM's data, address and write-enable
// inputs. Read data comes back over a valid/ready response channel.
//
// The RAM registers its read address at every clock edge. Its read output
// ram_q shows the word at that registered address combinationally.
// A read therefore takes two edges after acceptance:
//   - E1: the RAM latches the address.
//   - E2: ram_q is captured into rsp_data.
//
// Optional feature (macro DRAM_LSU_RANGE_CHK_EN):
//   Requests with req_addr >= DEPTH are out of range.
//   - An out-of-range write still steps through WR, but ram_we stays low.
//   - An out-of-range read keeps the normal read timing and returns
//     rsp_data = 0 with rsp_err = 1.
//   - Without the macro, rsp_err is always 0 and addresses are not checked.
//
// Parameters:
//   DATA_W  data word width
//   ADDR_W  RAM address width
//   DEPTH   number of valid RAM words (DEPTH <= 2**ADDR_W)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request (decoded from state)
//   req_we     1 = write, 0 = read
//   req_addr   request address
//   req_wdata  write data
//   rsp_valid  read response present
//   rsp_ready  consumer accepts the response
//   rsp_data   read data
//   rsp_err    response error flag (out-of-range read)
//   ram_data   RAM data input
//   ram_addr   RAM address input
//   ram_we     RAM write enable
//   ram_q      RAM read output
// ---------------------------------------------------------------------------
module dram_lsu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  // Reject impossible geometries at elaboration time.
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_check
    $error("dram_lsu: DEPTH must be in 1 .. 2**ADDR_W");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CAP,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic req_oor;
  logic cap_err;
  logic [DATA_W-1:0] cap_data;

  assign accept = req_valid & req_ready;

`ifdef DRAM_LSU_RANGE_CHK_EN
  // Compare one bit wider than the address, because DEPTH may equal
  // 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic oor_q;

  assign req_oor = ({1'b0, req_addr} >= DEPTH_LIM);

  // Remember whether the accepted read was out of range.
  // RD_CAP uses this flag to substitute a zero word and raise the error bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_q <= 1'b0;
    end else if (accept) begin
      oor_q <= req_oor;
    end
  end

  assign cap_err  = oor_q;
  assign cap_data = oor_q ? '0 : ram_q;
`else
  assign req_oor  = 1'b0;
  assign cap_err  = 1'b0;
  assign cap_data = ram_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the decoded req_ready.
  // rsp_valid is high for the whole of RESP, so only rsp_ready matters there.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = req_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        state_nxt = IDLE;
      end
      RD_ADDR: begin
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // RAM master side.
  // ram_addr and ram_data change only at an accept edge and hold otherwise.
  // ram_we is a one-cycle pulse that coincides with the WR state.
  // Out-of-range requests leave both registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_we <= 1'b0;
      if (accept && !req_oor) begin
        ram_addr <= req_addr;
        if (req_we) begin
          ram_data <= req_wdata;
          ram_we   <= 1'b1;
        end
      end
    end
  end

  // Response channel.
  // Data is captured at the RD_CAP edge and then held through RESP.
  // rsp_data keeps its value after the handshake; only rsp_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == RD_CAP) begin
        rsp_valid <= 1'b1;
        rsp_data  <= cap_data;
        rsp_err   <= cap_err;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
